// File: rtl/modbus_rtu_pkg.sv
// Shared types and constants for the Modbus RTU receive framer and CRC engine.
// Latency: n/a (types, constants and an elaboration-time timing function only).
// Backpressure: n/a.
package modbus_rtu_pkg;

    // One-hot framer states.
    typedef enum logic [5:0] {
        ST_INIT = 6'b000001,
        ST_IDLE = 6'b000010,
        ST_RECV = 6'b000100,
        ST_GAP  = 6'b001000,
        ST_DONE = 6'b010000,
        ST_DROP = 6'b100000
    } frame_state_t;

    // CRC-16/Modbus: reflected polynomial, all-ones preset.
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    // Silence thresholds in clock cycles. Above 19200 baud the character-time
    // formula gives intervals too short to be practical, so fixed 750 us /
    // 1750 us are used instead. 64-bit so CLK_FREQ*1750 cannot overflow.
    function automatic longint silence_ticks(input longint clk_hz,
                                             input longint baud,
                                             input bit     is_t35);
        if (baud > 64'd19200)
            return is_t35 ? (clk_hz * 1750) / 1000000 : (clk_hz * 750) / 1000000;
        else
            return is_t35 ? (clk_hz * 77) / (2 * baud) : (clk_hz * 33) / (2 * baud);
    endfunction

endpackage

// File: rtl/modbus_crc16.sv
// Byte-serial CRC-16/Modbus engine; shared by the RX framer and the TX framer.
// Latency: one byte per cycle, crc updated on the edge after enable.
// Backpressure: none; caller presents a byte with enable whenever it has one.
// Ports: sys_clk/reset_n; clear restarts from CRC_INIT (combined with enable it
// folds data into a fresh CRC); enable+data fold one byte; crc is the remainder.
module modbus_crc16
    import modbus_rtu_pkg::*;
(
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_next;

    always_comb begin
        crc_next = clear ? CRC_INIT : crc;
        crc_next = crc_next ^ {8'h00, data};
        for (int i = 0; i < 8; i++)
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            crc <= CRC_INIT;
        else if (enable)
            crc <= crc_next;
        else if (clear)
            crc <= CRC_INIT;
    end

endmodule

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame delimiter: buffers bytes, times t1.5/t3.5 silence, hands a frame to the decoder.
// Latency: frame_valid rises t3.5 after the last byte; rd_data is registered (1 cycle after rd_addr).
// Backpressure: one frame held until frame_ack; frames arriving meanwhile are dropped, not queued.
// Ports: rx_data/rx_done/rx_state from uart_byte_rx; frame_valid/frame_len/frame_err/crc_ok
// describe the held frame, frame_ack releases it; rd_addr/rd_data read the frame buffer.
// Option: define MODBUS_RTU_CRC_CHECK_EN to compute crc_ok; otherwise crc_ok is constant 0.
module modbus_rtu_frame_rx
    import modbus_rtu_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int MAX_LEN   = 256,
    parameter int LEN_W     = 9
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             rx_state,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_err,
    input  logic [7:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic             crc_ok
);

    localparam longint T15_L = silence_ticks(64'(CLK_FREQ), 64'(BAUD_RATE), 1'b0);
    localparam longint T35_L = silence_ticks(64'(CLK_FREQ), 64'(BAUD_RATE), 1'b1);
    localparam int     CNT_W = $clog2(T35_L + 1);
    localparam logic [CNT_W-1:0] T15 = CNT_W'(T15_L);
    localparam logic [CNT_W-1:0] T35 = CNT_W'(T35_L);
    localparam int     AW    = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MAX_LEN);

    frame_state_t     state;
    logic [CNT_W-1:0] silence;
    logic [LEN_W-1:0] wr_len;
    logic             err_acc;
    logic             at_t15;
    logic             at_t35;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             crc_match;
    logic [7:0]       mem [MAX_LEN];

    assign at_t15 = (silence == T15);
    assign at_t35 = (silence == T35);

    // Line-silence timer: any activity restarts it; saturates so INIT/GAP/DROP
    // can wait on "== T35" without wrap-around.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            silence <= '0;
        else if (rx_state || rx_done)
            silence <= '0;
        else if (!at_t35)
            silence <= silence + 1'b1;
    end

    // Only IDLE (first byte) and RECV (below capacity) store bytes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wr_len[AW-1:0];
        if (rx_done) begin
            if (state == ST_IDLE) begin
                wr_en   = 1'b1;
                wr_addr = '0;
            end else if (state == ST_RECV && wr_len != LEN_FULL) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem[wr_addr] <= rx_data;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr[AW-1:0]];
    end

`ifdef MODBUS_RTU_CRC_CHECK_EN
    logic [15:0] crc;

    modbus_crc16 u_crc (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .clear   (rx_done && state == ST_IDLE),
        .enable  (wr_en),
        .data    (rx_data),
        .crc     (crc)
    );

    // A frame ending in its own CRC (low byte first) leaves a zero remainder.
    assign crc_match = (crc == 16'h0000) && (wr_len >= LEN_W'(4));
`else
    assign crc_match = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            wr_len      <= '0;
            err_acc     <= 1'b0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            frame_err   <= 1'b0;
            crc_ok      <= 1'b0;
        end else begin
            case (state)
                // Wait for a full t3.5 of silence so we never lock on mid-frame.
                ST_INIT: if (at_t35) state <= ST_IDLE;
                ST_IDLE: if (rx_done) begin
                    wr_len  <= LEN_W'(1);
                    err_acc <= 1'b0;
                    state   <= ST_RECV;
                end
                ST_RECV: begin
                    if (rx_done) begin
                        if (wr_len == LEN_FULL) err_acc <= 1'b1;
                        else                    wr_len  <= wr_len + 1'b1;
                    end else if (at_t15) begin
                        state <= ST_GAP;
                    end
                end
                // Bytes after a t1.5 gap poison the frame but still count.
                ST_GAP: begin
                    if (rx_done) begin
                        err_acc <= 1'b1;
                        if (wr_len != LEN_FULL) wr_len <= wr_len + 1'b1;
                    end else if (at_t35) begin
                        state       <= ST_DONE;
                        frame_valid <= 1'b1;
                        frame_len   <= wr_len;
                        frame_err   <= err_acc;
                        crc_ok      <= crc_match;
                    end
                end
                ST_DONE: begin
                    if (frame_ack) begin
                        frame_valid <= 1'b0;
                        crc_ok      <= 1'b0;
                    end
                    if (rx_done)        state <= ST_DROP;
                    else if (frame_ack) state <= ST_IDLE;
                end
                // Discard a frame that arrived while one was held; the held frame
                // stays valid (and ackable) throughout.
                ST_DROP: begin
                    if (frame_ack && frame_valid) begin
                        frame_valid <= 1'b0;
                        crc_ok      <= 1'b0;
                    end
                    if (at_t35)
                        state <= (frame_valid && !frame_ack) ? ST_DONE : ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Directed self-checking bench for modbus_rtu_frame_rx.
// Clocked at a nominal 1 MHz so T15=750 and T35=1750 cycles (115200 baud > 19200).
// MAX_LEN=8 so the overflow case is reachable with short frames.
module tb_modbus_rtu_frame_rx;

    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 115200;
    localparam int MAX_LEN   = 8;
    localparam int LEN_W     = 4;
`ifdef MODBUS_RTU_CRC_CHECK_EN
    localparam logic CRC_EN = 1'b1;
`else
    localparam logic CRC_EN = 1'b0;
`endif

    logic             sys_clk;
    logic             reset_n;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic             rx_state;
    logic             frame_valid;
    logic             frame_ack;
    logic [LEN_W-1:0] frame_len;
    logic             frame_err;
    logic [7:0]       rd_addr;
    logic [7:0]       rd_data;
    logic             crc_ok;

    int vectors;
    int miscompares;

    modbus_rtu_frame_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .MAX_LEN   (MAX_LEN),
        .LEN_W     (LEN_W)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_state    (rx_state),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_len   (frame_len),
        .frame_err   (frame_err),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .crc_ok      (crc_ok)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One character: ~80 cycles on the wire, then the done strobe, short inter-byte idle.
    task automatic send_byte(input logic [7:0] b);
        rx_state = 1'b1;
        repeat (80) @(negedge sys_clk);
        rx_state = 1'b0;
        rx_data  = b;
        rx_done  = 1'b1;
        @(negedge sys_clk);
        rx_done = 1'b0;
        repeat (7) @(negedge sys_clk);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (frame_valid !== 1'b1 && n < 4000) begin
            @(negedge sys_clk);
            n++;
        end
        check(tag, 32'(frame_valid), 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        @(negedge sys_clk);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic ack_check(input string tag);
        frame_ack = 1'b1;
        @(negedge sys_clk);
        frame_ack = 1'b0;
        check(tag, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        rx_data     = 8'h00;
        rx_done     = 1'b0;
        rx_state    = 1'b0;
        frame_ack   = 1'b0;
        rd_addr     = 8'h00;
        repeat (3) @(negedge sys_clk);

        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_len",   32'(frame_len),   32'd0);
        check("rst_err",   32'(frame_err),   32'd0);
        check("rst_rdata", 32'(rd_data),     32'd0);
        check("rst_crc",   32'(crc_ok),      32'd0);
        reset_n = 1'b1;

        // Byte during INIT is ignored and restarts the t3.5 wait.
        repeat (1000) @(negedge sys_clk);
        send_byte(8'hEE);
        repeat (2200) @(negedge sys_clk);
        check("init_ignored", 32'(frame_valid), 32'd0);

        // Basic 4-byte frame.
        send_byte(8'hC2); send_byte(8'hB3); send_byte(8'hA4); send_byte(8'h95);
        wait_valid("t1_valid");
        check("t1_len", 32'(frame_len), 32'd4);
        check("t1_err", 32'(frame_err), 32'd0);
        read_check("t1_rd0", 8'd0, 8'hC2);
        read_check("t1_rd1", 8'd1, 8'hB3);
        read_check("t1_rd2", 8'd2, 8'hA4);
        read_check("t1_rd3", 8'd3, 8'h95);
        ack_check("t1_ack");

        // t1.5 violation: 3 bytes, gap between T15 and T35, one more byte.
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        repeat (1200) @(negedge sys_clk);
        check("t2_no_valid_in_gap", 32'(frame_valid), 32'd0);
        send_byte(8'h44);
        wait_valid("t2_valid");
        check("t2_err", 32'(frame_err), 32'd1);
        check("t2_len", 32'(frame_len), 32'd4);
        read_check("t2_rd0", 8'd0, 8'h11);
        read_check("t2_rd2", 8'd2, 8'h33);
        ack_check("t2_ack");

        // Stray ack with nothing held has no effect.
        frame_ack = 1'b1;
        @(negedge sys_clk);
        frame_ack = 1'b0;
        check("stray_ack", 32'(frame_valid), 32'd0);

        // Overflow: 9 bytes into an 8-byte buffer.
        for (int i = 0; i < 9; i++) send_byte(8'hA0 + 8'(i));
        wait_valid("t3_valid");
        check("t3_len", 32'(frame_len), 32'd8);
        check("t3_err", 32'(frame_err), 32'd1);
        read_check("t3_rd0", 8'd0, 8'hA0);
        read_check("t3_rd7", 8'd7, 8'hA7);
        ack_check("t3_ack");

        // Held frame survives a second frame; second is dropped; third is received.
        send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C);
        wait_valid("t4_valid_a");
        send_byte(8'hE1); send_byte(8'hE2);
        repeat (300) @(negedge sys_clk);
        check("t4_still_valid", 32'(frame_valid), 32'd1);
        check("t4_len_a", 32'(frame_len), 32'd3);
        check("t4_err_a", 32'(frame_err), 32'd0);
        read_check("t4_rd0", 8'd0, 8'h5A);
        read_check("t4_rd1", 8'd1, 8'h6B);
        ack_check("t4_ack_a");
        repeat (2200) @(negedge sys_clk);
        check("t4_b_dropped", 32'(frame_valid), 32'd0);
        send_byte(8'h3C); send_byte(8'h4D);
        wait_valid("t4_valid_c");
        check("t4_len_c", 32'(frame_len), 32'd2);
        check("t4_err_c", 32'(frame_err), 32'd0);
        read_check("t4_rd0_c", 8'd0, 8'h3C);
        read_check("t4_rd1_c", 8'd1, 8'h4D);
        ack_check("t4_ack_c");

        // Read Holding Registers request with correct CRC (84 0A).
        send_byte(8'h01); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h84); send_byte(8'h0A);
        wait_valid("t6_valid_good");
        check("t6_len_good", 32'(frame_len), 32'd8);
        check("t6_err_good", 32'(frame_err), 32'd0);
        check("t6_crc_good", 32'(crc_ok), 32'(CRC_EN));
        read_check("t6_rd6", 8'd6, 8'h84);
        ack_check("t6_ack_good");
        check("t6_crc_cleared", 32'(crc_ok), 32'd0);

        // Same frame with a corrupted CRC byte.
        send_byte(8'h01); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h85); send_byte(8'h0A);
        wait_valid("t6_valid_bad");
        check("t6_crc_bad", 32'(crc_ok), 32'd0);
        check("t6_err_bad", 32'(frame_err), 32'd0);
        check("t6_len_bad", 32'(frame_len), 32'd8);
        ack_check("t6_ack_bad");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
